// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter control for the TPU instruction path.
// Fetches 16-bit instructions from a synchronous-read memory, issues them to the
// control unit one per pulse, and stalls on VALID/STORE until the array is idle.
module instr_sequencer #(
    parameter int unsigned PC_W    = 13,
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            abort,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr_out,
    output logic            instr_valid,
    input  logic            dp_busy,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLDOFF);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_VALID = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWait,
        StDone
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic [2:0]      rd_op;
    logic [2:0]      iss_op;
    logic            pc_last;
    logic [PC_W-1:0] pc_inc;

    // While in ISSUE, instr_out still carries the instruction being issued.
    assign rd_op   = imem_rdata[15:13];
    assign iss_op  = instr_out[15:13];
    assign pc_last = (pc == {PC_W{1'b1}});
    assign pc_inc  = pc + PC_W'(1);

    // Sequencer FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StIdle;
            pc          <= '0;
            imem_en     <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            hold_cnt    <= '0;
            wd_cnt      <= '0;
        end else begin
            // Pulse outputs default low; each state raises what it needs.
            imem_en     <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;

            case (state)
                StIdle: begin
                    if (start) begin
                        pc        <= start_addr;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        imem_en   <= 1'b1;
                        imem_addr <= start_addr;
                        state     <= StFetch;
                    end
                end

                StFetch: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else begin
                        state <= StDecode;
                    end
                end

                StDecode: begin
                    if (abort || rd_op == OP_HALT) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else if (rd_op == OP_NOP || rd_op == OP_RSVD) begin
                        if (pc_last) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= StDone;
                        end else begin
                            pc        <= pc_inc;
                            imem_en   <= 1'b1;
                            imem_addr <= pc_inc;
                            state     <= StFetch;
                        end
                    end else begin
                        instr_out   <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end
                end

                StIssue: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else if (pc_last) begin
                        // No wrap: running off the end of memory is an error.
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else begin
                        pc <= pc_inc;
                        if (iss_op == OP_VALID || iss_op == OP_STORE) begin
                            hold_cnt <= '0;
                            wd_cnt   <= '0;
                            state    <= StWait;
                        end else begin
                            imem_en   <= 1'b1;
                            imem_addr <= pc_inc;
                            state     <= StFetch;
                        end
                    end
                end

                StWait: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else if (hold_cnt != HOLD_END) begin
                        // dp_busy may not reflect the new op yet; ignore it.
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else if (!dp_busy) begin
                        imem_en   <= 1'b1;
                        imem_addr <= pc;
                        state     <= StFetch;
                    end else if (wd_cnt == WD_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                StDone: begin
                    state <= StIdle;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a program-walking reference model checked every
// cycle, plus directed scenarios with hand-computed timing expectations.
module tb_instr_sequencer;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned HOLDOFF = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned DEPTH   = 1 << PC_W;
    localparam logic [PC_W-1:0] PC_MAX = '1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] start_addr = '0;
    logic            abort = 1'b0;
    logic            dp_busy = 1'b0;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata = '0;
    logic [15:0]     instr_out;
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            done;
    logic            err;

    logic [15:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    instr_sequencer #(
        .PC_W    (PC_W),
        .HOLDOFF (HOLDOFF),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .abort       (abort),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .dp_busy     (dp_busy),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) if (imem_en === 1'b1) imem_rdata <= mem[imem_addr];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PC_W-1:0] m_pc;
    logic            m_err;
    logic            e_en, e_valid, e_busy, e_done;
    logic [PC_W-1:0] e_addr;
    logic [15:0]     e_instr;
    logic            s_rst, s_abort, s_start, s_busy;
    logic [PC_W-1:0] s_addr;

    task automatic put(input logic en, input logic [PC_W-1:0] addr, input logic [15:0] ins,
                       input logic vld, input logic bsy, input logic dn);
        e_en = en; e_addr = addr; e_instr = ins; e_valid = vld; e_busy = bsy; e_done = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        s_rst = reset; s_abort = abort; s_start = start; s_addr = start_addr; s_busy = dp_busy;
    endtask

    task automatic m_reset();
        m_pc = '0;
        m_err = 1'b0;
        put(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // One done cycle, then back to idle.
    task automatic m_finish();
        put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        if (!s_rst) m_reset();
        else put(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic m_interrupted(output bit stop);
        stop = 1'b1;
        if (!s_rst) m_reset();
        else if (s_abort) m_finish();
        else stop = 1'b0;
    endtask

    // Walk the program: fetch, decode, optionally issue and wait, per instruction.
    task automatic m_run();
        logic [15:0] ins;
        logic [2:0]  op;
        int          hold;
        int          cnt;
        bit          stop;
        forever begin
            put(1'b1, m_pc, '0, 1'b0, 1'b1, 1'b0);
            tick(); m_interrupted(stop); if (stop) return;
            put(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            tick(); m_interrupted(stop); if (stop) return;
            ins = mem[m_pc];
            op  = ins[15:13];
            if (op == 3'd7) begin
                m_finish();
                return;
            end
            if (op == 3'd0 || op == 3'd6) begin
                if (m_pc == PC_MAX) begin
                    m_err = 1'b1;
                    m_finish();
                    return;
                end
                m_pc = m_pc + 1'b1;
                continue;
            end
            put(1'b0, '0, ins, 1'b1, 1'b1, 1'b0);
            tick(); m_interrupted(stop); if (stop) return;
            if (m_pc == PC_MAX) begin
                m_err = 1'b1;
                m_finish();
                return;
            end
            m_pc = m_pc + 1'b1;
            if (op == 3'd4 || op == 3'd5) begin
                hold = 0;
                cnt  = 0;
                forever begin
                    put(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
                    tick(); m_interrupted(stop); if (stop) return;
                    if (hold < int'(HOLDOFF)) hold++;
                    else if (!s_busy) break;
                    else begin
                        cnt++;
                        if (cnt == int'(TIMEOUT)) begin
                            m_err = 1'b1;
                            m_finish();
                            return;
                        end
                    end
                end
            end
        end
    endtask

    initial begin : model
        m_reset();
        forever begin
            tick();
            if (!s_rst) m_reset();
            else if (s_start) begin
                m_pc  = s_addr;
                m_err = 1'b0;
                m_run();
            end
        end
    end

    // ---------------- compare process and event logs ----------------
    int              v_cyc[$];
    logic [15:0]     v_ins[$];
    int              f_cyc[$];
    logic [PC_W-1:0] f_addr[$];
    int              d_cyc[$];
    logic [PC_W-1:0] d_pc[$];
    logic            d_err[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk_on) begin
                chk("imem_en", 16'(imem_en), 16'(e_en));
                chk("imem_addr", 16'(imem_addr), 16'(e_addr));
                chk("instr_out", instr_out, e_instr);
                chk("instr_valid", 16'(instr_valid), 16'(e_valid));
                chk("pc", 16'(pc), 16'(m_pc));
                chk("busy", 16'(busy), 16'(e_busy));
                chk("done", 16'(done), 16'(e_done));
                chk("err", 16'(err), 16'(m_err));
            end
            if (instr_valid === 1'b1) begin v_cyc.push_back(cyc); v_ins.push_back(instr_out); end
            if (imem_en === 1'b1) begin f_cyc.push_back(cyc); f_addr.push_back(imem_addr); end
            if (done === 1'b1) begin d_cyc.push_back(cyc); d_pc.push_back(pc); d_err.push_back(err); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        v_cyc.delete(); v_ins.delete(); f_cyc.delete(); f_addr.delete();
        d_cyc.delete(); d_pc.delete(); d_err.delete();
    endtask

    task automatic fill(input logic [15:0] val);
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = val;
    endtask

    task automatic pulse_start(input logic [PC_W-1:0] addr);
        @(negedge clk);
        start = 1'b1;
        start_addr = addr;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit && d_cyc.size() == 0; i++) @(negedge clk);
        if (d_cyc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no done pulse within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        for (int i = 0; i < limit && v_cyc.size() == 0; i++) @(negedge clk);
        if (v_cyc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no instr_valid within %0d cycles", name, limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a_cyc;
        int pct;
        fill(16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk_on = 1'b1;

        // Reset state
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_pc", 16'(pc), 16'h0);
        chk("rst_imem_en", 16'(imem_en), 16'h0);
        chk("rst_instr", instr_out, 16'h0);

        // 1: three issues spaced 3 cycles, then halt
        fill(16'h0000);
        mem[0] = 16'h2010; mem[1] = 16'h4000; mem[2] = 16'h6000; mem[3] = 16'hE000;
        clear_logs();
        pulse_start('0);
        wait_done("t1_done", 40);
        chk_int("t1_issue_count", v_ins.size(), 3);
        if (v_ins.size() == 3) begin
            chk("t1_ins0", v_ins[0], 16'h2010);
            chk("t1_ins1", v_ins[1], 16'h4000);
            chk("t1_ins2", v_ins[2], 16'h6000);
            chk_int("t1_spacing0", v_cyc[1] - v_cyc[0], 3);
            chk_int("t1_spacing1", v_cyc[2] - v_cyc[1], 3);
            chk_int("t1_fetch_to_valid", v_cyc[0] - f_cyc[0], 2);
        end
        if (d_cyc.size() > 0) begin
            chk("t1_done_pc", 16'(d_pc[0]), 16'h3);
            chk("t1_done_err", 16'(d_err[0]), 16'h0);
        end

        // 2: VALID stalls until dp_busy drops
        @(negedge clk);
        fill(16'h0000);
        mem[0] = 16'h8000; mem[1] = 16'hE000;
        clear_logs();
        pulse_start('0);
        wait_valid("t2_valid", 10);
        @(negedge clk);
        dp_busy = 1'b1;
        repeat (6) @(negedge clk);
        dp_busy = 1'b0;
        wait_done("t2_done", 40);
        chk_int("t2_fetch_count", f_cyc.size(), 2);
        if (f_cyc.size() == 2 && v_cyc.size() > 0) begin
            chk_int("t2_refetch_cycle", f_cyc[1] - v_cyc[0], 8);
            chk("t2_refetch_addr", 16'(f_addr[1]), 16'h1);
        end

        // 3: NOP and reserved opcode never issue
        @(negedge clk);
        fill(16'h0000);
        mem[0] = 16'h0000; mem[1] = 16'hC000; mem[2] = 16'hE000;
        clear_logs();
        pulse_start('0);
        wait_done("t3_done", 40);
        chk_int("t3_issue_count", v_ins.size(), 0);
        chk_int("t3_fetch_count", f_cyc.size(), 3);
        if (d_cyc.size() > 0) chk("t3_done_pc", 16'(d_pc[0]), 16'h2);

        // 4: watchdog timeout, then a fresh start clears err
        @(negedge clk);
        fill(16'h0000);
        mem[0] = 16'hA000;
        dp_busy = 1'b1;
        clear_logs();
        pulse_start('0);
        wait_done("t4_done", 60);
        if (d_cyc.size() > 0 && v_cyc.size() > 0) begin
            chk_int("t4_timeout_cycle", d_cyc[0] - v_cyc[0], 11);
            chk("t4_done_err", 16'(d_err[0]), 16'h1);
        end
        dp_busy = 1'b0;
        @(negedge clk);
        chk("t4_err_sticky", 16'(err), 16'h1);
        mem[0] = 16'hE000;
        clear_logs();
        pulse_start('0);
        chk("t4_err_cleared", 16'(err), 16'h0);
        wait_done("t4b_done", 20);

        // 5a: abort during WAIT
        @(negedge clk);
        mem[0] = 16'h8000;
        dp_busy = 1'b1;
        clear_logs();
        pulse_start('0);
        wait_valid("t5_valid", 10);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        a_cyc = cyc;
        @(negedge clk);
        abort = 1'b0;
        dp_busy = 1'b0;
        wait_done("t5_done", 10);
        if (d_cyc.size() > 0) begin
            chk_int("t5_abort_latency", d_cyc[0] - a_cyc, 1);
            chk("t5_abort_err", 16'(d_err[0]), 16'h0);
        end

        // 5b: reset while fetching
        @(negedge clk);
        clear_logs();
        pulse_start('0);
        chk("t5_in_fetch", 16'(imem_en), 16'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t5_rst_en", 16'(imem_en), 16'h0);
        chk("t5_rst_busy", 16'(busy), 16'h0);
        chk("t5_rst_pc", 16'(pc), 16'h0);
        @(negedge clk);
        chk_int("t5_rst_no_done", d_cyc.size(), 0);

        // 5c: start while busy is ignored
        fill(16'h0000);
        mem[0] = 16'h2010; mem[1] = 16'h4000; mem[2] = 16'hE000;
        clear_logs();
        pulse_start('0);
        @(negedge clk);
        start = 1'b1;
        start_addr = 4'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5c_done", 40);
        chk_int("t5c_fetch_count", f_cyc.size(), 3);
        if (d_cyc.size() > 0) chk("t5c_done_pc", 16'(d_pc[0]), 16'h2);

        // 6: PC overflow at the top of memory
        @(negedge clk);
        fill(16'h2001);
        clear_logs();
        pulse_start(4'd14);
        wait_done("t6_done", 40);
        chk_int("t6_issue_count", v_ins.size(), 2);
        if (f_addr.size() == 2) begin
            chk("t6_addr0", 16'(f_addr[0]), 16'd14);
            chk("t6_addr1", 16'(f_addr[1]), 16'd15);
        end
        if (d_cyc.size() > 0) begin
            chk("t6_done_err", 16'(d_err[0]), 16'h1);
            chk("t6_done_pc", 16'(d_pc[0]), 16'd15);
        end

        // Random phase: model checks every cycle
        for (int ep = 0; ep < 4; ep++) begin
            start = 1'b0;
            abort = 1'b0;
            dp_busy = 1'b0;
            reset = 1'b1;
            for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
            chk("rand_idle_before_refill", 16'(busy), 16'h0);
            for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'($urandom);
            pct = (ep == 3) ? 100 : 30 + 30 * ep;
            for (int i = 0; i < 700; i++) begin
                @(negedge clk);
                reset = ($urandom_range(0, 299) != 0);
                start = ($urandom_range(0, 5) == 0);
                start_addr = PC_W'($urandom_range(0, DEPTH - 1));
                abort = ($urandom_range(0, 59) == 0);
                dp_busy = ($urandom_range(0, 99) < pct);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
